// File: rtl/decoder_n_hold.sv
// decoder_n_hold: registered binary-to-one-hot decoder that holds each decoded line for HOLD cycles.
// Defining DECODER_OVERRUN_EN adds a sticky overrun flag for requests refused while busy.
module decoder_n_hold #(
   parameter int SEL_W = 2,
   parameter int HOLD  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SEL_W-1:0]     d_in,
   output logic [2**SEL_W-1:0]  d_out,
   output logic                 out_valid
`ifdef DECODER_OVERRUN_EN
   ,
   output logic                 overrun
`endif
);
   localparam int CW = HOLD > 1 ? $clog2(HOLD) : 1;
   localparam logic [2**SEL_W-1:0] ONE = 1;
   typedef enum logic {ST_IDLE, ST_HOLD} state_t;
   if (HOLD < 1 || HOLD > 65535) begin : g_bad_hold
      $error("decoder_n_hold: HOLD must be in 1..65535");
   end
   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2**SEL_W-1:0] d_out_d;
   logic                out_valid_d;
   logic                accept;
   assign in_ready = state_q == ST_IDLE || cnt_q == '0;
   assign accept   = in_valid && in_ready;
   // a new code on the last hold cycle reloads directly, giving gap-free back-to-back pulses
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      d_out_d     = d_out;
      out_valid_d = out_valid;
      if (accept) begin
         state_d     = ST_HOLD;
         cnt_d       = CW'(HOLD - 1);
         d_out_d     = ONE << d_in;
         out_valid_d = 1'b1;
      end else if (state_q == ST_HOLD && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end else if (state_q == ST_HOLD) begin
         state_d     = ST_IDLE;
         d_out_d     = '0;
         out_valid_d = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         d_out     <= '0;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         d_out     <= d_out_d;
         out_valid <= out_valid_d;
      end
   end
`ifdef DECODER_OVERRUN_EN
   always_ff @(posedge clk) begin
      if (rst) overrun <= 1'b0;
      else if (in_valid && !in_ready) overrun <= 1'b1;
   end
`endif
endmodule

// File: tb/tb_decoder_n_hold.sv
// tb_decoder_n_hold: directed plus random stimulus against a pulse-schedule reference model.
// Exercises the overrun flag when DECODER_OVERRUN_EN is defined.
module tb_decoder_n_hold;
   localparam int SEL_W = 2;
   localparam int HOLD  = 4;
   localparam int N     = 2**SEL_W;
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [SEL_W-1:0] d_in = '0;
   logic [N-1:0]     d_out;
   logic             out_valid;
   int               total = 0;
   int               bad = 0;
   int               m_left = 0;
   int               m_code = 0;
`ifdef DECODER_OVERRUN_EN
   logic             overrun;
   bit               m_ovr = 1'b0;
`endif
   always #5 clk = ~clk;
   decoder_n_hold #(.SEL_W(SEL_W), .HOLD(HOLD)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .d_in(d_in),
      .d_out(d_out),
      .out_valid(out_valid)
`ifdef DECODER_OVERRUN_EN
      ,
      .overrun(overrun)
`endif
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   // model: m_left counts remaining cycles of the current pulse; a code is taken when at most one remains
   task automatic step(input logic r, input logic v, input int d, input string tag);
      bit rdy;
      rst      = r;
      in_valid = v;
      d_in     = SEL_W'(d);
      rdy      = m_left <= 1;
      @(posedge clk);
`ifdef DECODER_OVERRUN_EN
      if (r) m_ovr = 1'b0;
      else if (v && !rdy) m_ovr = 1'b1;
`endif
      if (r) m_left = 0;
      else if (v && rdy) begin
         m_left = HOLD;
         m_code = d % N;
      end else if (m_left > 0) m_left--;
      @(negedge clk);
      check({tag, ".d_out"}, 32'(d_out), m_left > 0 ? 32'd1 << m_code : 32'd0);
      check({tag, ".out_valid"}, 32'(out_valid), 32'(m_left > 0));
      check({tag, ".in_ready"}, 32'(in_ready), 32'(m_left <= 1));
`ifdef DECODER_OVERRUN_EN
      check({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
`endif
   endtask
   initial begin
      step(1, 0, 0, "reset");
      step(1, 1, 3, "reset_with_valid");
      check("reset.idle_zero", 32'(d_out), 32'd0);
      step(0, 1, 2, "single_accept");
      for (int i = 0; i < HOLD + 2; i++) step(0, 0, 1, "single_hold");
      for (int i = 0; i < 4 * HOLD + 2; i++) step(0, i < 4 * HOLD, i / HOLD, "walk");
      for (int i = 0; i < 3 * HOLD; i++) step(0, 1, i, "toggle");
      for (int i = 0; i < HOLD; i++) step(0, 0, 0, "drain");
      step(0, 1, 3, "mid_accept");
      step(0, 0, 0, "mid_hold1");
      step(1, 1, 2, "mid_reset");
      step(0, 1, 1, "after_reset");
      for (int i = 0; i < HOLD + 1; i++) step(0, 0, 2, "after_hold");
      step(0, 1, 0, "ovr_accept");
      step(0, 1, 1, "ovr_refused");
      for (int i = 0; i < HOLD + 1; i++) step(0, 0, 0, "ovr_sticky");
      for (int i = 0; i < 400; i++)
         step($urandom_range(39) == 0, $urandom_range(1) == 1, int'($urandom_range(N - 1)), "rand");
      for (int i = 0; i < HOLD + 1; i++) step(0, 0, 0, "final");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/decoder_n_hold.md
Name: decoder_n_hold

Overview:
- Registered binary-to-one-hot decoder with a pulse-hold sequencer. It is the receive-side counterpart of the 4:2 encoder family.
- Accepts a SEL_W-bit code through a valid/ready handshake and drives the matching one-hot line of d_out for exactly HOLD clock cycles. It then either returns to all-zero or switches directly to the next accepted code.
- Used where encoded selects must be turned back into timed strobes, e.g. driving LEDs, enables or mux selects from a 2-bit bus.

Parameters:
- SEL_W, 2, width of the input code; d_out width is 2**SEL_W (4 by default).
- HOLD, 4, number of cycles each decoded line stays asserted. Legal range 1..65535. Elaboration fails with $error outside this range.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  d_in carries a code to decode.
- in_ready  output  1  block can accept a code this cycle.
- d_in  input  SEL_W  binary code to decode.
- d_out  output  2**SEL_W  registered one-hot output; all-zero when idle.
- out_valid  output  1  high while d_out is driving a decoded line.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Reset is sampled on the rising edge of clk only.
- Reset values:
  - d_out = 0, out_valid = 0, state = IDLE, hold counter = 0.
  - in_ready reads 1 once reset is released.
- Counter: width is clog2(HOLD), minimum 1 bit.
- States: IDLE and HOLD. All outputs are registered except in_ready, which is combinational from state and counter only, never from in_valid.
- in_ready = (state == IDLE) OR (state == HOLD AND cnt == 0).
- Accept: a transfer occurs on a rising edge where in_valid AND in_ready are both high.
- Latency: one cycle. On the edge after the accept:
  - d_out has bit d_in set and all other bits clear.
  - out_valid = 1, state = HOLD, cnt = HOLD-1.
- HOLD state:
  - cnt decrements each cycle while cnt > 0; d_out and out_valid are held.
- HOLD with cnt == 0:
  - If in_valid = 1, the new code is loaded on that edge with no gap: d_out switches one-hot directly, cnt reloads to HOLD-1, and the block stays in HOLD.
  - Otherwise d_out goes to 0, out_valid goes to 0, and the block returns to IDLE.
- Result: out_valid is high for exactly HOLD consecutive cycles per accepted code. Back-to-back codes produce a continuous out_valid with d_out changing on HOLD boundaries.
- HOLD = 1: cnt is always 0 and in_ready is constantly 1, so the block is a registered decoder with a valid flag.
- in_valid while in_ready = 0: the code is not taken and state is unchanged. Upstream must hold d_in and in_valid until the accept.
- d_in is sampled only on the accept edge. Changes at other times have no effect.
- Reset mid-HOLD: on the reset edge d_out and out_valid clear and state returns to IDLE. No partial pulse continues after reset.
- Reset and in_valid together: reset wins and no code is accepted.

Optional Feature:
- Macro DECODER_OVERRUN_EN adds output port overrun (1 bit). The flag is sticky and set on any edge where in_valid = 1 and in_ready = 0. It clears only on rst.
- Without the macro, the port and logic are absent and refused requests are silently stalled as described above.

Test Plan:
- Defaults (SEL_W = 2, HOLD = 4): reset, then present d_in = 2'b10 with in_valid for 1 cycle.
  - Response: next cycle d_out = 4'b0100 and out_valid = 1, both held for exactly 4 cycles, then d_out = 4'b0000 and out_valid = 0.
- Walk d_in through 00, 01, 10, 11 back-to-back with in_valid held high.
  - in_ready is high only in IDLE and on the last hold cycle.
  - d_out steps 0001, 0010, 0100, 1000, each for 4 cycles; out_valid stays continuously high for 16 cycles.
- Hold in_valid = 1 and toggle d_in every cycle during HOLD.
  - Only codes present on accept edges appear on d_out. Intermediate values never appear.
- Assert rst for 1 cycle at the 2nd hold cycle of code 11.
  - Next cycle d_out = 0, out_valid = 0, in_ready = 1. A following request for 01 gives d_out = 0010 for 4 cycles.
- HOLD = 1 build: in_valid held high with d_in stepping each cycle.
  - d_out follows d_in one-hot with 1-cycle latency; in_ready stays 1 throughout.
- With DECODER_OVERRUN_EN: assert in_valid in hold cycle 1 (in_ready = 0).
  - overrun goes to 1 on that edge and stays 1 until rst.
  - Without the macro, the same stimulus only stalls.
